// File: rtl/controlo_tara_pkg.sv
// Shared types, defaults and the tare-subtraction helper for controlo_tara.
// CONTROLO_TARA_SAT_EN selects saturating instead of wrapping subtraction.
package controlo_tara_pkg;

  typedef enum logic {
    PESAR    = 1'b0,
    ADQUIRIR = 1'b1
  } estado_t;

  localparam int TARA_INICIAL_DEF   = 50;
  localparam int LOG2_N_DEF         = 2;
  localparam int LIMIAR_ESTAVEL_DEF = 2;
  localparam int CONT_ESTAVEL_DEF   = 8;

  localparam logic signed [15:0] MAX_S16 = 16'sh7FFF;
  localparam logic signed [15:0] MIN_S16 = 16'sh8000;
  localparam logic signed [16:0] MAX_S17 = 17'sd32767;
  localparam logic signed [16:0] MIN_S17 = -17'sd32768;

  function automatic logic signed [15:0] diferenca(input logic [15:0] a, input logic [15:0] t);
`ifdef CONTROLO_TARA_SAT_EN
    logic signed [16:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, t});
    if (d > MAX_S17)      return MAX_S16;
    else if (d < MIN_S17) return MIN_S16;
    else                  return d[15:0];
`else
    return $signed(a - t);
`endif
  endfunction

endpackage

// File: rtl/controlo_tara_if.sv
// Sample/button/result bundle between the ADC source, controlo_tara and display logic.
interface controlo_tara_if;
  logic [15:0]        amostra;
  logic               amostra_valida;
  logic               btn_tara;
  logic               btn_limpar;
  logic signed [15:0] resultado;
  logic               resultado_valido;
  logic [15:0]        tara_reg;
  logic               ocupado;
  logic               estavel;

  modport master (
    output amostra, amostra_valida, btn_tara, btn_limpar,
    input  resultado, resultado_valido, tara_reg, ocupado, estavel
  );

  modport slave (
    input  amostra, amostra_valida, btn_tara, btn_limpar,
    output resultado, resultado_valido, tara_reg, ocupado, estavel
  );
endinterface

// File: rtl/controlo_tara_detetor_estabilidade.sv
// Net-weight stability detector: saturating count of consecutive small deltas.
module detetor_estabilidade #(
  parameter int LIMIAR = 2,
  parameter int CONT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] novo,
  input  logic               novo_valido,
  input  logic               limpar,
  output logic               estavel
);
  localparam int CW = $clog2(CONT + 1);

  logic signed [15:0] prev;
  logic               tem_prev;
  logic [CW-1:0]      cont, cont_n;
  logic signed [16:0] delta;
  logic [16:0]        mag;

  always_comb begin
    delta  = $signed({novo[15], novo}) - $signed({prev[15], prev});
    mag    = (delta < 0) ? 17'(-delta) : 17'(delta);
    cont_n = '0;
    // a result with no predecessor never counts as stable
    if (tem_prev && (mag <= 17'(LIMIAR)))
      cont_n = (cont < CW'(CONT)) ? cont + 1'b1 : cont;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      tem_prev <= 1'b0;
      cont     <= '0;
      estavel  <= 1'b0;
    end else if (limpar) begin
      tem_prev <= 1'b0;
      cont     <= '0;
      estavel  <= 1'b0;
    end else if (novo_valido) begin
      prev     <= novo;
      tem_prev <= 1'b1;
      cont     <= cont_n;
      estavel  <= (cont_n == CW'(CONT));
    end
  end
endmodule

// File: rtl/controlo_tara.sv
// Tare controller: averages 2^LOG2_N samples into the tare, subtracts it from weights.
// Build option CONTROLO_TARA_SAT_EN: saturate the net result instead of wrapping.
module controlo_tara
  import controlo_tara_pkg::*;
#(
  parameter int TARA_INICIAL   = TARA_INICIAL_DEF,
  parameter int LOG2_N         = LOG2_N_DEF,
  parameter int LIMIAR_ESTAVEL = LIMIAR_ESTAVEL_DEF,
  parameter int CONT_ESTAVEL   = CONT_ESTAVEL_DEF
) (
  input logic            clk,
  input logic            rst,
  controlo_tara_if.slave bus
);
  localparam logic [LOG2_N-1:0] CNT_ULT = '1;

  estado_t             estado, estado_n;
  logic [15+LOG2_N:0]  acc, soma;
  logic [LOG2_N-1:0]   cnt;
  logic                limpar_det, fim, pesa;
  logic signed [15:0]  resultado;
  logic                resultado_valido;
  logic [15:0]         tara;

  assign pesa = (estado == PESAR) && bus.amostra_valida;
  assign soma = acc + {{LOG2_N{1'b0}}, bus.amostra};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= PESAR;
    else     estado <= estado_n;
  end

  always_comb begin
    estado_n   = estado;
    limpar_det = 1'b0;
    fim        = 1'b0;
    case (estado)
      PESAR: begin
        if (bus.btn_limpar) begin
          limpar_det = 1'b1;
        end else if (bus.btn_tara) begin
          estado_n   = ADQUIRIR;
          limpar_det = 1'b1;
        end
      end
      ADQUIRIR: begin
        if (bus.btn_limpar) begin
          estado_n   = PESAR;
          limpar_det = 1'b1;
        end else if (bus.amostra_valida && (cnt == CNT_ULT)) begin
          fim      = 1'b1;
          estado_n = PESAR;
        end
      end
      default: estado_n = PESAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tara             <= 16'(TARA_INICIAL);
      resultado        <= '0;
      resultado_valido <= 1'b0;
      acc              <= '0;
      cnt              <= '0;
    end else begin
      resultado_valido <= pesa;
      if (pesa) resultado <= diferenca(bus.amostra, tara);
      if (bus.btn_limpar) tara <= '0;
      else if (fim)       tara <= soma[15+LOG2_N:LOG2_N];
      // accumulator only runs while acquiring; any exit discards the partial sum
      if (estado == PESAR || bus.btn_limpar) begin
        acc <= '0;
        cnt <= '0;
      end else if (bus.amostra_valida) begin
        acc <= soma;
        cnt <= cnt + 1'b1;
      end
    end
  end

  detetor_estabilidade #(
    .LIMIAR (LIMIAR_ESTAVEL),
    .CONT   (CONT_ESTAVEL)
  ) u_estab (
    .clk         (clk),
    .rst         (rst),
    .novo        (diferenca(bus.amostra, tara)),
    .novo_valido (pesa),
    .limpar      (limpar_det),
    .estavel     (bus.estavel)
  );

  assign bus.resultado        = resultado;
  assign bus.resultado_valido = resultado_valido;
  assign bus.tara_reg         = tara;
  assign bus.ocupado          = (estado == ADQUIRIR);
endmodule

// File: doc/controlo_tara.md
Name: controlo_tara

Overview:
Tare controller for the digital scale datapath. Sequences tare acquisition from a button press by averaging 2^LOG2_N raw samples, holds the tare value, and subtracts it from every raw weight sample. Flags when the net weight is stable. Sits between the ADC sample source and the display/price logic; replaces the fixed-constant tare subtraction.

Parameters:
TARA_INICIAL, 50, tare value loaded at reset (raw units)
LOG2_N, 2, log2 of number of samples averaged during tare acquisition (N = 4)
LIMIAR_ESTAVEL, 2, max |delta| between consecutive net results still counted as stable
CONT_ESTAVEL, 8, consecutive stable results required to assert estavel

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
amostra  input  16  raw unsigned weight sample
amostra_valida  input  1  amostra valid this cycle (single-cycle strobe)
btn_tara  input  1  debounced single-cycle pulse: start tare acquisition
btn_limpar  input  1  debounced single-cycle pulse: clear tare to 0
resultado  output  16 signed  net weight = amostra - tara_reg
resultado_valido  output  1  one-cycle strobe, resultado updated
tara_reg  output  16  current tare value
ocupado  output  1  high during tare acquisition
estavel  output  1  net weight stable

Behaviour:
- Reset (async, rst=1): state=PESAR, tara_reg=TARA_INICIAL, resultado=0, resultado_valido=0, ocupado=0, estavel=0, accumulator=0, sample counter=0, stability counter=0.
- States: PESAR (weigh), ADQUIRIR (acquire tare).
- PESAR: on amostra_valida, resultado <= amostra - tara_reg, resultado_valido=1 on the next cycle only. Latency 1 cycle. Default arithmetic: 16-bit two's-complement wrap.
- PESAR + btn_tara -> ADQUIRIR next cycle. Clear accumulator, sample counter, stability counter; estavel=0; ocupado=1 from the next cycle.
- PESAR, same cycle amostra_valida and btn_tara: that sample is processed as a weight using the old tare. Acquisition counts only from later samples.
- ADQUIRIR: each amostra_valida adds amostra to a (16+LOG2_N)-bit accumulator and increments the counter. No resultado_valido strobes. resultado holds its last value.
- After the Nth sample: tara_reg <= (accumulator + that sample) >> LOG2_N (truncate), state -> PESAR. ocupado=0 from the following cycle.
- btn_tara in ADQUIRIR: ignored.
- btn_limpar in any state: tara_reg <= 0, state -> PESAR, acquisition aborted (partial sum discarded), ocupado=0, stability counter=0, estavel=0. Takes priority over btn_tara in the same cycle.
- btn_limpar same cycle as amostra_valida in PESAR: the sample uses the old tare. The clear takes effect from the next sample.
- Stability, evaluated on each new resultado:
  - If |resultado_new - resultado_prev| <= LIMIAR_ESTAVEL: counter++, saturating at CONT_ESTAVEL.
  - Otherwise: counter=0.
  - estavel = (counter == CONT_ESTAVEL), registered.
  - The first result after reset, limpar, or tare has no predecessor: counter=0.
- Reset mid-acquisition: returns immediately to the reset values above.

Optional Feature:
Macro: CONTROLO_TARA_SAT_EN
- Defined: difference computed 17-bit signed and saturated to [-32768, 32767] before registering.
- Undefined: plain 16-bit wrap.
- Everything else is identical in both builds.

Decomposition:
- Shared include controlo_tara_defs.vh: state encodings (PESAR, ADQUIRIR), defaults for TARA_INICIAL, LOG2_N, LIMIAR_ESTAVEL, CONT_ESTAVEL, signed limits 16'sh7FFF/16'sh8000.
- One sub-module, detetor_estabilidade:
  - Inputs: clk, rst, novo resultado + strobe, clear.
  - Output: estavel.
  - Holds the previous-value register and the saturating counter.

Test Plan:
- Reset then amostra=1000 valid -> next cycle resultado=950, resultado_valido=1 for exactly 1 cycle, tara_reg=50.
- btn_tara, then samples 200,202,204,206 -> ocupado=1 throughout, no result strobes, tara_reg=203, ocupado=0. Then amostra=303 -> resultado=100.
- btn_tara, 2 samples, btn_limpar -> tara_reg=0, ocupado=0. Next amostra=77 -> resultado=77. btn_tara+btn_limpar in the same cycle -> limpar wins.
- Stability: 8 samples of 500 (tare 0) -> estavel rises with the 9th result. Samples 500,500,503 -> counter reset, estavel=0. A 502 after 500 counts as stable.
- amostra=10, tara 50 -> resultado=16'hFFD8 (-40). With tara=0, amostra=65535: no macro -> 16'hFFFF (-1); CONTROLO_TARA_SAT_EN defined -> 16'h7FFF.
- rst asserted mid-acquisition after 3 samples -> all outputs and tara_reg return to reset values asynchronously. Next sample is treated as a weight.
